// File: rtl/int_sum_v3.sv
// int_sum_v3 -- streaming block-sum engine on the shared accelerator bus.
//
// Reads N words from input_addr onward, splits each word into
// DATA_WIDTH/ELEM_WIDTH elements, and reduces them as signed or unsigned
// values. mode 0 writes one sum per block to output_addr + blk; mode 1
// writes a single total to output_addr. overflow is sticky and flags any
// written result that does not fit in OUTPUT_WIDTH bits.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   acc_valid/addr/wdata/wstrb  bus request (wstrb == 0 means read)
//   acc_ready               request accepted at this clock edge
//   acc_rdata, acc_rvalid   read return, rvalid is a one-cycle pulse
//   start                   one-cycle start pulse, sampled only when idle
//   input_addr, output_addr, N, mode, signed_en   job configuration
//   done                    one-cycle completion pulse
//   busy                    job in progress
//   overflow                sticky result-range flag
//   dbg_state               current FSM state
//
// Handshake: a request is transferred on a rising clk edge where acc_valid
// and acc_ready are both high. While acc_valid is high and not yet
// accepted, acc_addr/acc_wdata/acc_wstrb hold steady. acc_valid drops in
// the cycle after acceptance, so at most one request or read is in flight.
module int_sum_v3 #(
  parameter int DATA_WIDTH   = 256,
  parameter int ELEM_WIDTH   = 32,
  parameter int OUTPUT_WIDTH = 32,
  parameter int ADDR_WIDTH   = 19
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      acc_valid,
  output logic [ADDR_WIDTH-1:0]     acc_addr,
  output logic [DATA_WIDTH-1:0]     acc_wdata,
  output logic [DATA_WIDTH/8-1:0]   acc_wstrb,
  input  logic [DATA_WIDTH-1:0]     acc_rdata,
  input  logic                      acc_rvalid,
  input  logic                      acc_ready,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     input_addr,
  input  logic [ADDR_WIDTH-1:0]     output_addr,
  input  logic [31:0]               N,
  input  logic                      mode,
  input  logic                      signed_en,
  output logic                      done,
  output logic                      busy,
  output logic                      overflow,
  output logic [2:0]                dbg_state
);

  localparam int NUM  = DATA_WIDTH / ELEM_WIDTH;
  localparam int SUMW = ELEM_WIDTH + $clog2(NUM) + 1;
  localparam int ACCW = OUTPUT_WIDTH + 33;
  localparam int SB   = DATA_WIDTH / 8;
  localparam int OB   = OUTPUT_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_SUM     = 3'd3,
    S_WR_REQ  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_in_base;
  logic [ADDR_WIDTH-1:0] r_out_base;
  logic [31:0]           r_n;
  logic                  r_mode;
  logic                  r_signed;
  logic [31:0]           r_blk;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ACCW-1:0]       r_acc;
  logic                  r_wr_ovf;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SB-1:0]         r_wstrb;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_ovf;

  logic [SUMW-1:0]       w_blk_sum;
  logic [ACCW-1:0]       w_blk_ext;
  logic [ACCW-1:0]       w_tot;
  logic [ACCW-1:0]       w_new;
  logic                  w_new_ovf;
  logic [31:0]           w_blk_nxt;
  logic                  w_last;

  // Each element is widened to SUMW bits (sign bit replicated only when
  // signed), so the reduction is exact for either interpretation.
  always_comb begin
    w_blk_sum = '0;
    for (int i = 0; i < NUM; i++) begin
      w_blk_sum = w_blk_sum +
        {{(SUMW-ELEM_WIDTH){r_signed & r_data[i*ELEM_WIDTH+ELEM_WIDTH-1]}},
         r_data[i*ELEM_WIDTH +: ELEM_WIDTH]};
    end
  end

  // Unsigned sums always have a zero top bit, so a plain sign extension
  // is correct in both modes.
  assign w_blk_ext = {{(ACCW-SUMW){w_blk_sum[SUMW-1]}}, w_blk_sum};
  assign w_tot     = r_acc + w_blk_ext;
  assign w_new     = r_mode ? w_tot : w_blk_ext;

  // Signed fits iff bits [ACCW-1:OW-1] are all equal; unsigned fits iff
  // every bit above OW-1 is zero.
  assign w_new_ovf = r_signed ?
    !((&w_new[ACCW-1:OUTPUT_WIDTH-1]) | ~(|w_new[ACCW-1:OUTPUT_WIDTH-1])) :
    (|w_new[ACCW-1:OUTPUT_WIDTH]);

  assign w_blk_nxt = r_blk + 32'd1;
  assign w_last    = (w_blk_nxt == r_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_base  <= '0;
      r_out_base <= '0;
      r_n        <= '0;
      r_mode     <= 1'b0;
      r_signed   <= 1'b0;
      r_blk      <= '0;
      r_data     <= '0;
      r_acc      <= '0;
      r_wr_ovf   <= 1'b0;
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_in_base  <= input_addr;
            r_out_base <= output_addr;
            r_n        <= N;
            r_mode     <= mode;
            r_signed   <= signed_en;
            r_blk      <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            if (N == 32'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RD_REQ;
              r_busy  <= 1'b1;
              r_valid <= 1'b1;
              r_addr  <= input_addr;
              r_wstrb <= '0;
            end
          end
        end
        S_RD_REQ: begin
          // Entered with valid low after a write so that the bus sees a
          // deasserted cycle between requests; raise it here.
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_addr  <= r_in_base + r_blk[ADDR_WIDTH-1:0];
            r_wstrb <= '0;
          end else if (acc_ready) begin
            r_valid <= 1'b0;
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (acc_rvalid) begin
            r_data  <= acc_rdata;
            r_state <= S_SUM;
          end
        end
        S_SUM: begin
          if (r_mode) begin
            r_acc <= w_tot;
            r_blk <= w_blk_nxt;
          end
          if (!r_mode || w_last) begin
            r_state  <= S_WR_REQ;
            r_valid  <= 1'b1;
            r_addr   <= r_mode ? r_out_base : r_out_base + r_blk[ADDR_WIDTH-1:0];
            r_wdata  <= DATA_WIDTH'(w_new[OUTPUT_WIDTH-1:0]);
            r_wstrb  <= SB'({OB{1'b1}});
            r_wr_ovf <= w_new_ovf;
          end else begin
            r_state <= S_RD_REQ;
            r_valid <= 1'b1;
            r_addr  <= r_in_base + w_blk_nxt[ADDR_WIDTH-1:0];
            r_wstrb <= '0;
          end
        end
        S_WR_REQ: begin
          if (acc_ready) begin
            r_valid <= 1'b0;
            r_wstrb <= '0;
            r_ovf   <= r_ovf | r_wr_ovf;
            if (r_mode || w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_blk   <= w_blk_nxt;
              r_state <= S_RD_REQ;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign acc_valid = r_valid;
  assign acc_addr  = r_addr;
  assign acc_wdata = r_wdata;
  assign acc_wstrb = r_wstrb;
  assign done      = r_done;
  assign busy      = r_busy;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;

endmodule
